// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO push arbiter and related schedulers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Default configuration widths
    localparam int IDX_W = $clog2(4);
    localparam int CNT_W = $clog2(4 + 1);

    // Index width for n requesters (at least one bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Burst counter width able to hold 0..max_burst
    function automatic int cnt_w(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set request at or after a start pointer, wrapping.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        i_req,
    input  logic [idx_w(N)-1:0] i_start,
    output logic                o_found,
    output logic [idx_w(N)-1:0] o_idx
);

    localparam int IW = idx_w(N);

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(i_start) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (i_req[j]) begin
                o_found = 1'b1;
                o_idx   = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter granting one producer at a time bursts into a shared FIFO push port.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_push,
    output logic [WIDTH-1:0]           fifo_data,
    output logic [$clog2(NUM_REQ)-1:0] fifo_src,
    output logic                       busy
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = cnt_w(MAX_BURST);

    arb_state_t    r_state;
    logic [IW-1:0] r_grant_id;
    logic [CW-1:0] r_burst_cnt;
    logic [IW-1:0] r_rr_ptr;

    arb_state_t    w_state_nxt;
    logic [IW-1:0] w_grant_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [IW-1:0] w_ptr_nxt;

    logic          w_found;
    logic [IW-1:0] w_pick_idx;
    logic          w_in_grant;
    logic          w_beat;
    logic          w_last;
    logic [IW-1:0] w_after_grant;

    rr_priority_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .i_req  (req_valid),
        .i_start(r_rr_ptr),
        .o_found(w_found),
        .o_idx  (w_pick_idx)
    );

    // Grant-path qualifiers; reset_n gates them so nothing is accepted in a reset cycle
    always_comb begin
        w_in_grant    = (r_state == GRANT) && reset_n;
        w_beat        = w_in_grant && req_valid[r_grant_id] && !fifo_full;
        w_last        = (r_burst_cnt == CW'(MAX_BURST - 1));
        w_after_grant = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    end

    // Output muxing driven from the registered grant
    always_comb begin
        req_ready = '0;
        if (w_in_grant && !fifo_full) begin
            req_ready[r_grant_id] = 1'b1;
        end
        fifo_push = w_beat;
        fifo_data = req_data[int'(r_grant_id)*WIDTH +: WIDTH];
        fifo_src  = r_grant_id;
        busy      = w_in_grant;
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_cnt_nxt   = r_burst_cnt;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req_valid[r_grant_id] || (w_beat && w_last)) begin
                    w_ptr_nxt   = w_after_grant;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (w_beat) begin
                    w_cnt_nxt   = r_burst_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_id  <= w_grant_nxt;
            r_burst_cnt <= w_cnt_nxt;
            r_rr_ptr    <= w_ptr_nxt;
        end
    end

endmodule
